// File: rtl/meduram_wr_arbiter_pkg.sv
// Shared constants, write-port bundle type and round-robin helper for the
// MEDURAM write arbiter.
package meduram_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      en;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wr_bundle_t;

    // Written as a compare rather than '%' so it stays correct for any n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/meduram_wr_arbiter_if.sv
// Requester handshake bus plus the two RAM write ports driven by the arbiter.
interface meduram_wr_arbiter_if
    import meduram_arb_pkg::*;
#(
    parameter int NB_REQ     = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NB_REQ-1:0]            req_valid;
    logic [NB_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NB_REQ*DATA_WIDTH-1:0] req_data;
    logic [NB_REQ-1:0]            req_ready;
    logic                         wren1;
    logic [ADDR_WIDTH-1:0]        wraddr1;
    logic [DATA_WIDTH-1:0]        wrdata1;
    logic                         wren2;
    logic [ADDR_WIDTH-1:0]        wraddr2;
    logic [DATA_WIDTH-1:0]        wrdata2;

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wren1, wraddr1, wrdata1, wren2, wraddr2, wrdata2
    );

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wren1, wraddr1, wrdata1, wren2, wraddr2, wrdata2
    );
endinterface

// File: rtl/meduram_rr_pick2.sv
// Combinational picker: first two valid requesters scanning from i_ptr,
// the second required to target a different address than the first.
module meduram_rr_pick2 #(
    parameter int NB_REQ     = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int PW         = 2
) (
    input  logic [PW-1:0]                i_ptr,
    input  logic [NB_REQ-1:0]            i_valid,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] i_addr,
    output logic [PW-1:0]                o_a_idx,
    output logic                         o_a_found,
    output logic [PW-1:0]                o_b_idx,
    output logic                         o_b_found,
    output logic                         o_conflict
);
    logic [PW:0]           w_sum;
    logic [PW-1:0]         w_idx;
    logic [ADDR_WIDTH-1:0] w_a_addr;
    logic [ADDR_WIDTH-1:0] w_cur_addr;

    // Rotating scan; i_ptr < NB_REQ so a single conditional subtract wraps it.
    always_comb begin
        o_a_idx    = '0;
        o_a_found  = 1'b0;
        o_b_idx    = '0;
        o_b_found  = 1'b0;
        o_conflict = 1'b0;
        w_sum      = '0;
        w_idx      = '0;
        w_a_addr   = '0;
        w_cur_addr = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            w_sum      = {1'b0, i_ptr} + (PW+1)'(k);
            w_idx      = (w_sum >= (PW+1)'(NB_REQ)) ? PW'(w_sum - (PW+1)'(NB_REQ)) : w_sum[PW-1:0];
            w_cur_addr = i_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
            if (i_valid[w_idx]) begin
                if (!o_a_found) begin
                    o_a_found = 1'b1;
                    o_a_idx   = w_idx;
                    w_a_addr  = w_cur_addr;
                end else if (w_cur_addr == w_a_addr) begin
                    o_conflict = 1'b1;
                end else if (!o_b_found) begin
                    o_b_found = 1'b1;
                    o_b_idx   = w_idx;
                end else begin
                    o_b_found = o_b_found;
                end
            end else begin
                o_conflict = o_conflict;
            end
        end
    end
endmodule

// File: rtl/meduram_wr_arbiter.sv
// Round-robin arbiter sharing the two RAM write ports among NB_REQ requesters.
// Optional MEDURAM_ARB_STATS_EN adds saturating stall/conflict counters.
module meduram_wr_arbiter
    import meduram_arb_pkg::*;
#(
    parameter int NB_REQ     = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    meduram_wr_arbiter_if.slave  bus
`ifdef MEDURAM_ARB_STATS_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          conflict_cnt
`endif
);
    localparam int PW = $clog2(NB_REQ);

    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } port_t;

    logic [PW-1:0]     r_ptr;
    port_t             r_p1;
    port_t             r_p2;
    logic [PW-1:0]     w_a_idx;
    logic [PW-1:0]     w_b_idx;
    logic              w_a_found;
    logic              w_b_found;
    logic              w_conflict;
    logic [NB_REQ-1:0] w_ready;

    meduram_rr_pick2 #(
        .NB_REQ     (NB_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PW         (PW)
    ) u_pick (
        .i_ptr      (r_ptr),
        .i_valid    (bus.req_valid),
        .i_addr     (bus.req_addr),
        .o_a_idx    (w_a_idx),
        .o_a_found  (w_a_found),
        .o_b_idx    (w_b_idx),
        .o_b_found  (w_b_found),
        .o_conflict (w_conflict)
    );

    // Grant vector, forced low while reset is held.
    always_comb begin
        w_ready = '0;
        if (aresetn) begin
            if (w_a_found) begin
                w_ready[w_a_idx] = 1'b1;
            end else begin
                w_ready = w_ready;
            end
            if (w_b_found) begin
                w_ready[w_b_idx] = 1'b1;
            end else begin
                w_ready = w_ready;
            end
        end else begin
            w_ready = '0;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wren1     = r_p1.en;
    assign bus.wraddr1   = r_p1.addr;
    assign bus.wrdata1   = r_p1.data;
    assign bus.wren2     = r_p2.en;
    assign bus.wraddr2   = r_p2.addr;
    assign bus.wrdata2   = r_p2.data;

    // Output ports and rotation pointer; idle ports keep their last addr/data.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_ptr <= '0;
            r_p1  <= '0;
            r_p2  <= '0;
        end else begin
            r_p1.en <= w_a_found;
            r_p2.en <= w_b_found;
            if (w_a_found) begin
                r_p1.addr <= bus.req_addr[w_a_idx*ADDR_WIDTH +: ADDR_WIDTH];
                r_p1.data <= bus.req_data[w_a_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_b_found) begin
                r_p2.addr <= bus.req_addr[w_b_idx*ADDR_WIDTH +: ADDR_WIDTH];
                r_p2.data <= bus.req_data[w_b_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_b_found) begin
                r_ptr <= PW'(rr_next(32'(w_b_idx), 32'(NB_REQ)));
            end else if (w_a_found) begin
                r_ptr <= PW'(rr_next(32'(w_a_idx), 32'(NB_REQ)));
            end
        end
    end

`ifdef MEDURAM_ARB_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_conflict_cnt;
    logic        w_stall;

    assign w_stall      = |(bus.req_valid & ~w_ready);
    assign stall_cnt    = r_stall_cnt;
    assign conflict_cnt = r_conflict_cnt;

    // Saturating statistics counters.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_stall_cnt    <= 32'd0;
            r_conflict_cnt <= 32'd0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_conflict && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end
`endif
endmodule
